// File: rtl/regfile_cmd_master_pkg.sv
// Shared constants for the register-file command master: frame width,
// command opcodes and the 3-bit FSM state encoding.
package regfile_cmd_master_pkg;

  localparam int unsigned FRAME_WIDTH = 8;

  localparam logic [FRAME_WIDTH-1:0] CMD_WR_OP = 8'hAA;
  localparam logic [FRAME_WIDTH-1:0] CMD_RD_OP = 8'hBB;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_WR_ADDR = 3'd1;
  localparam logic [STATE_W-1:0] ST_WR_DATA = 3'd2;
  localparam logic [STATE_W-1:0] ST_RD_ADDR = 3'd3;
  localparam logic [STATE_W-1:0] ST_RD_WAIT = 3'd4;
  localparam logic [STATE_W-1:0] ST_TX_SEND = 3'd5;

endpackage

// File: rtl/regfile_cmd_master.sv
// Decodes UART command frames into register-file writes/reads and returns
// read data to the UART transmitter under a busy handshake.
module regfile_cmd_master
  import regfile_cmd_master_pkg::*;
#(
  parameter int unsigned             WIDTH      = FRAME_WIDTH,
  parameter int unsigned             ADDR       = 4,
  parameter int unsigned             RD_TIMEOUT = 15,
  parameter logic [FRAME_WIDTH-1:0]  CMD_WR     = CMD_WR_OP,
  parameter logic [FRAME_WIDTH-1:0]  CMD_RD     = CMD_RD_OP
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] RX_P_DATA,
  input  logic             RX_D_VLD,
  output logic             WrEn,
  output logic             RdEn,
  output logic [ADDR-1:0]  Address,
  output logic [WIDTH-1:0] WrData,
  input  logic [WIDTH-1:0] RdData,
  input  logic             RdData_VLD,
  output logic [WIDTH-1:0] TX_P_DATA,
  output logic             TX_D_VLD,
  input  logic             TX_BUSY,
  output logic             ERR
);

  localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [ADDR-1:0]    addr_nxt;
  logic [WIDTH-1:0]   wr_data_nxt;
  logic [WIDTH-1:0]   tx_data_nxt;
  logic               wr_en_nxt;
  logic               rd_en_nxt;
  logic               tx_vld_nxt;
  logic               err_nxt;
  logic               addr_ok;

  // Address bytes must not carry bits above the register address range.
  if (ADDR < WIDTH) begin : g_range
    assign addr_ok = (RX_P_DATA[WIDTH-1:ADDR] == '0);
  end else begin : g_full
    assign addr_ok = 1'b1;
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    addr_nxt    = Address;
    wr_data_nxt = WrData;
    tx_data_nxt = TX_P_DATA;
    wr_en_nxt   = 1'b0;
    rd_en_nxt   = 1'b0;
    tx_vld_nxt  = 1'b0;
    err_nxt     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_WR) begin
            state_nxt = ST_WR_ADDR;
          end else if (RX_P_DATA == CMD_RD) begin
            state_nxt = ST_RD_ADDR;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      ST_WR_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_ok) begin
            addr_nxt  = RX_P_DATA[ADDR-1:0];
            state_nxt = ST_WR_DATA;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end

      ST_WR_DATA: begin
        if (RX_D_VLD) begin
          wr_data_nxt = RX_P_DATA;
          wr_en_nxt   = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end

      ST_RD_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_ok) begin
            addr_nxt  = RX_P_DATA[ADDR-1:0];
            rd_en_nxt = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_RD_WAIT;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end

      ST_RD_WAIT: begin
        // Overrun flags the dropped byte; the read itself keeps going.
        if (RX_D_VLD) begin
          err_nxt = 1'b1;
        end
        if (RdData_VLD) begin
          tx_data_nxt = RdData;
          cnt_nxt     = '0;
          state_nxt   = ST_TX_SEND;
        end else if (cnt == CNT_LAST) begin
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ST_TX_SEND: begin
        if (RX_D_VLD) begin
          err_nxt = 1'b1;
        end
        if (!TX_BUSY) begin
          tx_vld_nxt = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      Address   <= '0;
      WrData    <= '0;
      TX_P_DATA <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      TX_D_VLD  <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      Address   <= addr_nxt;
      WrData    <= wr_data_nxt;
      TX_P_DATA <= tx_data_nxt;
      WrEn      <= wr_en_nxt;
      RdEn      <= rd_en_nxt;
      TX_D_VLD  <= tx_vld_nxt;
      ERR       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_cmd_master.sv
// Randomized frame-level bench for regfile_cmd_master with a behavioural
// register-file responder and a transaction-level expectation model.
module tb_regfile_cmd_master;

  localparam int RD_TO = 15;
  localparam logic [7:0] OP_WR = 8'hAA;
  localparam logic [7:0] OP_RD = 8'hBB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       wr_en;
  logic       rd_en;
  logic [3:0] address;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_vld;
  logic [7:0] tx_data;
  logic       tx_vld;
  logic       tx_busy;
  logic       err;

  regfile_cmd_master #(
    .WIDTH(8), .ADDR(4), .RD_TIMEOUT(RD_TO), .CMD_WR(OP_WR), .CMD_RD(OP_RD)
  ) dut (
    .CLK(clk), .RST(rst_n), .RX_P_DATA(rx_data), .RX_D_VLD(rx_vld),
    .WrEn(wr_en), .RdEn(rd_en), .Address(address), .WrData(wr_data),
    .RdData(rd_data), .RdData_VLD(rd_vld), .TX_P_DATA(tx_data),
    .TX_D_VLD(tx_vld), .TX_BUSY(tx_busy), .ERR(err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Environment register file (what the DUT really writes) and the
  // bench's own idea of its contents.
  logic [7:0] env_mem [16];
  logic [7:0] model_mem [16];
  int rd_lat = -1;

  logic [3:0]  wr_a_q [$];
  logic [7:0]  wr_d_q [$];
  int unsigned rd_c_q [$];
  logic [3:0]  rd_a_q [$];
  logic [7:0]  tx_d_q [$];
  int unsigned tx_c_q [$];
  int unsigned err_c_q [$];
  int          both_cnt = 0;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_a_q.push_back(address);
      wr_d_q.push_back(wr_data);
      env_mem[address] <= wr_data;
    end
    if (rd_en) begin
      rd_a_q.push_back(address);
      rd_c_q.push_back(cyc);
    end
    if (tx_vld) begin
      tx_d_q.push_back(tx_data);
      tx_c_q.push_back(cyc);
    end
    if (err) err_c_q.push_back(cyc);
    if (wr_en && rd_en) both_cnt <= both_cnt + 1;
  end

  // Read responder: RdData_VLD rd_lat cycles after the RdEn cycle; -1 = never.
  initial begin
    logic [3:0] a;
    rd_vld  = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      if (rd_en && rd_lat >= 0) begin
        a = address;
        repeat (rd_lat) @(negedge clk);
        rd_data = env_mem[a];
        rd_vld  = 1'b1;
        @(negedge clk);
        rd_vld  = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_vld  = 1'b1;
    @(negedge clk);
    rx_vld  = 1'b0;
  endtask

  task automatic clear_ev();
    wr_a_q.delete(); wr_d_q.delete(); rd_a_q.delete(); rd_c_q.delete();
    tx_d_q.delete(); tx_c_q.delete(); err_c_q.delete();
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    clear_ev();
    send_byte(OP_WR); send_byte({4'h0, a}); send_byte(d);
    idle(3);
    model_mem[a] = d;
    check_eq("wr_cnt", 32'(wr_a_q.size()), 32'd1);
    if (wr_a_q.size() > 0) begin
      check_eq("wr_addr", 32'(wr_a_q[0]), 32'(a));
      check_eq("wr_data", 32'(wr_d_q[0]), 32'(d));
    end
    check_eq("wr_err", 32'(err_c_q.size()), 32'd0);
    check_eq("wr_no_rd", 32'(rd_a_q.size()), 32'd0);
  endtask

  // Frame that must end in exactly one ERR and no register/TX strobe.
  task automatic do_bad(input string tag, input logic [7:0] b0, input logic [7:0] b1, input int nbytes);
    clear_ev();
    send_byte(b0);
    if (nbytes > 1) send_byte(b1);
    idle(3);
    check_eq({tag, "_err"}, 32'(err_c_q.size()), 32'd1);
    check_eq({tag, "_strobes"}, 32'(wr_a_q.size() + rd_a_q.size() + tx_d_q.size()), 32'd0);
  endtask

  task automatic do_read(input logic [3:0] a, input int lat, input int busy);
    int unsigned r;
    int unsigned cb;
    bit ok;
    clear_ev();
    rd_lat  = lat;
    tx_busy = (busy > 0);
    cb = 0;
    send_byte(OP_RD); send_byte({4'h0, a});
    if (busy > 0) begin
      idle(busy);
      check_eq("bp_no_tx", 32'(tx_d_q.size()), 32'd0);
      tx_busy = 1'b0;
      cb = cyc;
    end
    idle(RD_TO + 4);
    rd_lat = -1;
    ok = (lat >= 0) && (lat <= RD_TO - 1);
    r = 0;
    check_eq("rd_cnt", 32'(rd_a_q.size()), 32'd1);
    if (rd_a_q.size() > 0) begin
      r = rd_c_q[0];
      check_eq("rd_addr", 32'(rd_a_q[0]), 32'(a));
    end
    check_eq("rd_no_wr", 32'(wr_a_q.size()), 32'd0);
    if (ok) begin
      check_eq("tx_cnt", 32'(tx_d_q.size()), 32'd1);
      if (tx_d_q.size() > 0) begin
        check_eq("tx_data", 32'(tx_d_q[0]), 32'(model_mem[a]));
        check_eq("tx_cycle", tx_c_q[0], (busy > 0) ? cb + 1 : r + 32'(lat) + 2);
      end
      check_eq("rd_err", 32'(err_c_q.size()), 32'd0);
    end else begin
      check_eq("to_no_tx", 32'(tx_d_q.size()), 32'd0);
      check_eq("to_err_cnt", 32'(err_c_q.size()), 32'd1);
      if (err_c_q.size() > 0) check_eq("to_err_cycle", err_c_q[0], r + RD_TO);
    end
  endtask

  initial begin
    logic [7:0] v;
    int unsigned cb;
    int kind;
    logic [3:0] a;
    logic [7:0] d;
    int lat;

    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom);
      env_mem[i]   = v;
      model_mem[i] = v;
    end
    rst_n = 1'b0; rx_data = '0; rx_vld = 1'b0; tx_busy = 1'b0;
    idle(2);
    check_eq("reset_outs", 32'({wr_en, rd_en, address, wr_data, tx_data, tx_vld, err}), 32'd0);
    rst_n = 1'b1;
    idle(2);

    do_write(4'd5, 8'h3C);
    do_read(4'd5, 1, 0);
    do_write(4'd2, 8'h81);
    do_read(4'd2, 1, 0);
    do_read(4'd2, 1, 20);

    do_bad("bad_cmd", 8'h55, 8'h00, 1);
    do_bad("bad_wr_addr", OP_WR, 8'h1F, 2);
    do_bad("bad_rd_addr", OP_RD, 8'h80, 2);

    // Overrun while waiting on a busy transmitter.
    clear_ev();
    rd_lat = 1; tx_busy = 1'b1;
    send_byte(OP_RD); send_byte(8'h05);
    idle(3);
    send_byte(8'h77);
    idle(2);
    tx_busy = 1'b0;
    cb = cyc;
    idle(3);
    rd_lat = -1;
    check_eq("ovr_err", 32'(err_c_q.size()), 32'd1);
    check_eq("ovr_tx_cnt", 32'(tx_d_q.size()), 32'd1);
    if (tx_d_q.size() > 0) begin
      check_eq("ovr_tx_data", 32'(tx_d_q[0]), 32'(model_mem[5]));
      check_eq("ovr_tx_cycle", tx_c_q[0], cb + 1);
    end

    do_read(4'd1, -1, 0);
    do_write(4'd9, 8'hA5);
    do_read(4'd3, RD_TO - 1, 0);
    do_read(4'd9, 0, 0);

    // RdData_VLD outside a read must be ignored.
    clear_ev();
    @(negedge clk);
    rd_data = 8'hEE; rd_vld = 1'b1;
    @(negedge clk);
    rd_vld = 1'b0;
    idle(3);
    check_eq("spurious_vld", 32'(tx_d_q.size() + err_c_q.size()), 32'd0);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 5);
      a = 4'($urandom);
      d = 8'($urandom);
      case (kind)
        0: do_write(a, d);
        1: do_bad("rnd_bad_wr", OP_WR, {4'($urandom_range(1, 15)), a}, 2);
        2: do_read(a, $urandom_range(0, RD_TO - 1), 0);
        3: do_read(a, -1, 0);
        4: begin
          if (d == OP_WR || d == OP_RD) d = 8'h00;
          do_bad("rnd_bad_cmd", d, 8'h00, 1);
        end
        default: begin
          lat = $urandom_range(0, 4);
          do_read(a, lat, lat + 2 + $urandom_range(0, 10));
        end
      endcase
    end

    // Reset in the middle of a write frame.
    clear_ev();
    send_byte(OP_WR); send_byte(8'h07);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_outs", 32'({wr_en, rd_en, address, wr_data, tx_data, tx_vld, err}), 32'd0);
    idle(2);
    rst_n = 1'b1;
    clear_ev();
    send_byte(8'h3C);
    idle(3);
    check_eq("midrst_err", 32'(err_c_q.size()), 32'd1);
    check_eq("midrst_no_wr", 32'(wr_a_q.size()), 32'd0);

    check_eq("wr_rd_excl", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
